// File: rtl/button_debounce_ctrl.sv
// Shared-timebase push-button debouncer: 2-flop sync, one prescaler,
// and a four-state stability FSM per channel with registered outputs.
module button_debounce_ctrl #(
  parameter int N_BTN        = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int STABLE_TICKS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } state_t;

  logic [N_BTN-1:0] meta;
  logic [N_BTN-1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
    end
  end

  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;

  assign pcnt_nxt = (pcnt == PMAX) ? '0 : pcnt + PW'(1);

  // tick is a flop that tracks pcnt == DIV-1 without a decode path
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= pcnt_nxt;
      tick <= (pcnt_nxt == PMAX);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          press_nxt;
    logic          rel_nxt;
    logic          level_q;
    logic          press_q;
    logic          rel_q;

    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= STABLE_LO;
        cnt     <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        level_q <= (state_nxt == STABLE_HI) ||
                   (state_nxt == CHK_LO);
        press_q <= press_nxt;
        rel_q   <= rel_nxt;
      end
    end

    // a level flip back aborts before any same-cycle tick is counted
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      unique case (state)
        STABLE_LO: begin
          if (sync[i]) begin
            state_nxt = CHK_HI;
            cnt_nxt   = '0;
          end
        end
        CHK_HI: begin
          if (!sync[i]) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
          end else if (tick) begin
            if (cnt_inc == CMAX) begin
              state_nxt = STABLE_HI;
              cnt_nxt   = '0;
              press_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
        end
        STABLE_HI: begin
          if (!sync[i]) begin
            state_nxt = CHK_LO;
            cnt_nxt   = '0;
          end
        end
        CHK_LO: begin
          if (sync[i]) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
          end else if (tick) begin
            if (cnt_inc == CMAX) begin
              state_nxt = STABLE_LO;
              cnt_nxt   = '0;
              rel_nxt   = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
        end
        default: begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
  end

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Scoreboard bench for button_debounce_ctrl: stimulus queues expected
// pulses with latency windows, a negedge monitor pops and compares.
module tb_button_debounce_ctrl;

  localparam int DIV = 10;
  localparam int LAT_MIN = 24;
  localparam int LAT_MAX = 33;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = 4'b0;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       tick;

  button_debounce_ctrl #(
    .N_BTN       (4),
    .CLK_HZ      (1000),
    .TICK_HZ     (100),
    .STABLE_TICKS(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] press;
    logic [3:0] rel;
    int         lo;
    int         hi;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         tc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       rst_d = 1'b1;
  logic [3:0] exp_level = 4'b0;

  // reference timebase: reset seen at an edge zeroes the prescaler
  always @(posedge clk) begin
    cyc++;
    rst_d = reset;
    if (reset) tc = 0;
    else tc = (tc == DIV - 1) ? 0 : tc + 1;
  end

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%b required=%b",
               nm, cyc, act, exp);
    end
  endtask

  exp_t       e;
  logic [3:0] pulses;

  always @(negedge clk) begin
    if (rst_d) exp_level = 4'b0;
    chk("tick", {3'b0, tick}, {3'b0, tc == DIV - 1});
    chk("press_and_release", btn_press & btn_release, 4'b0);
    pulses = btn_press | btn_release;
    if (pulses != 4'b0) begin
      if (rst_d || q.size() == 0) begin
        chk("unexpected_pulse", pulses, 4'b0);
      end else begin
        e = q.pop_front();
        chk({e.name, "_press"}, btn_press, e.press);
        chk({e.name, "_release"}, btn_release, e.rel);
        n_chk++;
        if (cyc < e.lo || cyc > e.hi) begin
          n_fail++;
          $display("FAIL %s_latency actual_cyc=%0d required=%0d..%0d",
                   e.name, cyc, e.lo, e.hi);
        end
        exp_level = (exp_level | e.press) & ~e.rel;
      end
    end else if (q.size() != 0 && cyc > q[0].hi) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_missing actual=no pulse by cyc %0d required=pulse by %0d",
               q[0].name, cyc, q[0].hi);
      q.delete(0);
    end
    chk("level", btn_level, exp_level);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic want(input string nm,
                      input logic [3:0] p,
                      input logic [3:0] r);
    exp_t x;
    x.press = p;
    x.rel   = r;
    x.lo    = cyc + LAT_MIN;
    x.hi    = cyc + LAT_MAX;
    x.name  = nm;
    q.push_back(x);
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 4'b0;
    step(5);
    reset = 1'b0;
    step(35);

    btn_raw[0] = 1'b1;
    want("clean_press", 4'b0001, 4'b0);
    step(40);
    btn_raw[0] = 1'b0;
    want("clean_release", 4'b0, 4'b0001);
    step(40);

    for (int i = 0; i < 10; i++) begin
      btn_raw[0] = ~btn_raw[0];
      step(4);
    end
    btn_raw[0] = 1'b1;
    want("bounce_press", 4'b0001, 4'b0);
    step(40);
    for (int i = 0; i < 10; i++) begin
      btn_raw[0] = ~btn_raw[0];
      step(4);
    end
    btn_raw[0] = 1'b0;
    want("bounce_release", 4'b0, 4'b0001);
    step(40);

    btn_raw = 4'b1010;
    want("simul_press", 4'b1010, 4'b0);
    step(40);
    btn_raw = 4'b0000;
    want("simul_release", 4'b0, 4'b1010);
    step(40);

    // drop lands so sync[2] falls in the cycle of the third tick
    for (int i = 0; i < 20 && tc != 0; i++) step(1);
    btn_raw[2] = 1'b1;
    step(27);
    btn_raw[2] = 1'b0;
    step(40);
    btn_raw[2] = 1'b1;
    want("requal_press", 4'b0100, 4'b0);
    step(40);
    btn_raw[2] = 1'b0;
    want("requal_release", 4'b0, 4'b0100);
    step(40);

    btn_raw[1] = 1'b1;
    want("hold_press", 4'b0010, 4'b0);
    step(40);
    btn_raw[0] = 1'b1;
    step(10);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    want("post_reset_press", 4'b0011, 4'b0);
    step(40);
    btn_raw = 4'b0000;
    want("final_release", 4'b0, 4'b0011);
    step(40);

    for (int i = 0; i < 60 && q.size() != 0; i++) step(1);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_leftover actual=%0d entries required=0",
               q.size());
    end
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
